ones_counter_unit: RTL and testbench



---
 rtl/ones_counter_pkg.sv | 11 +
 rtl/popcount_tree.sv | 45 ++++
 rtl/ones_counter_unit.sv | 67 ++++++
 tb/tb_ones_counter_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ones_counter_pkg.sv
// Shared definitions for the ones counter: default word width and count-width helper.
package ones_counter_pkg;

  localparam int DEF_DATA_W = 8;

  // Bits needed to hold a count from 0 up to and including w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational population count, built as a recursive balanced adder tree.
module popcount_tree
  import ones_counter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = cnt_width(DATA_W)
) (
  input  logic [DATA_W-1:0] data_in,
  output logic [CNT_W-1:0]  cnt
);

  generate
    if (DATA_W == 1) begin : g_leaf
      assign cnt = CNT_W'(data_in);
    end else begin : g_node
      // The high half takes the odd bit so both subtrees stay within one level of each other.
      localparam int LO_W     = DATA_W / 2;
      localparam int HI_W     = DATA_W - LO_W;
      localparam int LO_CNT_W = cnt_width(LO_W);
      localparam int HI_CNT_W = cnt_width(HI_W);

      logic [LO_CNT_W-1:0] w_cnt_lo;
      logic [HI_CNT_W-1:0] w_cnt_hi;

      popcount_tree #(
        .DATA_W (LO_W),
        .CNT_W  (LO_CNT_W)
      ) u_lo (
        .data_in (data_in[LO_W-1:0]),
        .cnt     (w_cnt_lo)
      );

      popcount_tree #(
        .DATA_W (HI_W),
        .CNT_W  (HI_CNT_W)
      ) u_hi (
        .data_in (data_in[DATA_W-1:LO_W]),
        .cnt     (w_cnt_hi)
      );

      assign cnt = CNT_W'(w_cnt_lo) + CNT_W'(w_cnt_hi);
    end
  endgenerate

endmodule

// File: rtl/ones_counter_unit.sv
// Registered population count with parity and all-zero/all-one flags, one-cycle latency.
module ones_counter_unit
  import ones_counter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = cnt_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              parity_out,
  output logic              all_zero,
  output logic              all_ones
);

  logic [CNT_W-1:0] w_cnt;
  logic             w_parity;
  logic             w_all_zero;
  logic             w_all_ones;

  logic             r_out_valid;
  logic [CNT_W-1:0] r_cnt;
  logic             r_parity;
  logic             r_all_zero;
  logic             r_all_ones;

  popcount_tree #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_popcount_tree (
    .data_in (data_in),
    .cnt     (w_cnt)
  );

  assign w_parity   = ^data_in;
  assign w_all_zero = ~|data_in;
  assign w_all_ones = &data_in;

  // Result registers only load on valid, so X on an idle bus never reaches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
      r_parity    <= 1'b0;
      r_all_zero  <= 1'b1;
      r_all_ones  <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_cnt      <= w_cnt;
        r_parity   <= w_parity;
        r_all_zero <= w_all_zero;
        r_all_ones <= w_all_ones;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign cnt_out    = r_cnt;
  assign parity_out = r_parity;
  assign all_zero   = r_all_zero;
  assign all_ones   = r_all_ones;

endmodule

// File: tb/tb_ones_counter_unit.sv
// Directed self-checking bench for ones_counter_unit, plus width sweep at DATA_W = 1, 7, 16.
module tb_ones_counter_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] data_in;
  logic       out_valid;
  logic [3:0] cnt_out;
  logic       parity_out;
  logic       all_zero;
  logic       all_ones;

  logic [0:0]  d1;
  logic [6:0]  d7;
  logic [15:0] d16;
  logic        v1, v7, v16;
  logic [0:0]  c1;
  logic [2:0]  c7;
  logic [4:0]  c16;
  logic        p1, p7, p16;
  logic        z1, z7, z16;
  logic        o1, o7, o16;

  int n_chk;
  int n_pass;

  ones_counter_unit #(.DATA_W(8)) u_dut (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .data_in (data_in),
    .out_valid (out_valid), .cnt_out (cnt_out), .parity_out (parity_out),
    .all_zero (all_zero), .all_ones (all_ones)
  );

  ones_counter_unit #(.DATA_W(1)) u_w1 (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .data_in (d1),
    .out_valid (v1), .cnt_out (c1), .parity_out (p1),
    .all_zero (z1), .all_ones (o1)
  );

  ones_counter_unit #(.DATA_W(7)) u_w7 (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .data_in (d7),
    .out_valid (v7), .cnt_out (c7), .parity_out (p7),
    .all_zero (z7), .all_ones (o7)
  );

  ones_counter_unit #(.DATA_W(16)) u_w16 (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .data_in (d16),
    .out_valid (v16), .cnt_out (c16), .parity_out (p16),
    .all_zero (z16), .all_ones (o16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"},  64'(out_valid),  64'd0);
    chk({tag, ".cnt"},    64'(cnt_out),    64'd0);
    chk({tag, ".parity"}, 64'(parity_out), 64'd0);
    chk({tag, ".zero"},   64'(all_zero),   64'd1);
    chk({tag, ".ones"},   64'(all_ones),   64'd0);
  endtask

  function automatic int ref_pop(input logic [7:0] w);
    int n = 0;
    for (int b = 0; b < 8; b++) if (w[b]) n++;
    return n;
  endfunction

  // word, expected count, parity, all_zero, all_ones (hand computed)
  localparam int NV = 8;
  logic [7:0] v_word [NV] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h00, 8'hFF, 8'h80};
  logic [3:0] v_cnt  [NV] = '{4'd2,  4'd2,  4'd2,  4'd4,  4'd3,  4'd0,  4'd8,  4'd1};
  logic       v_par  [NV] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
  logic       v_az   [NV] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
  logic       v_ao   [NV] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};

  logic [7:0] s_word [9];

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    d1 = '0; d7 = '0; d16 = '0;

    #12;
    chk_reset("reset");

    // Idle after release with X on the bus must leave reset values in place.
    @(negedge clk);
    rst_n   = 1'b1;
    data_in = 'x;
    repeat (2) @(negedge clk);
    chk_reset("idle_x");

    // Directed words back to back; each result checked on the following negedge.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        in_valid = 1'b1;
        data_in  = v_word[i];
      end else begin
        in_valid = 1'b0;
        data_in  = 8'hFF;
      end
      @(negedge clk);
      if (i < NV) begin
        chk($sformatf("dir%0d.valid", i),  64'(out_valid),  64'd1);
        chk($sformatf("dir%0d.cnt", i),    64'(cnt_out),    64'(v_cnt[i]));
        chk($sformatf("dir%0d.parity", i), 64'(parity_out), 64'(v_par[i]));
        chk($sformatf("dir%0d.zero", i),   64'(all_zero),   64'(v_az[i]));
        chk($sformatf("dir%0d.ones", i),   64'(all_ones),   64'(v_ao[i]));
      end
    end

    // in_valid low with 8'hFF on the bus: strobe drops, last result (8'h80) held.
    chk("gate.valid",  64'(out_valid),  64'd0);
    chk("gate.cnt",    64'(cnt_out),    64'd1);
    chk("gate.parity", 64'(parity_out), 64'd1);
    chk("gate.ones",   64'(all_ones),   64'd0);

    // Nine back-to-back random words.
    for (int i = 0; i < 9; i++) s_word[i] = 8'($urandom);
    for (int i = 0; i <= 9; i++) begin
      in_valid = (i < 9);
      data_in  = (i < 9) ? s_word[i] : 8'h00;
      @(negedge clk);
      if (i < 9) begin
        chk($sformatf("stream%0d.valid", i), 64'(out_valid), 64'd1);
        chk($sformatf("stream%0d.cnt", i),   64'(cnt_out),   64'(ref_pop(s_word[i])));
      end
    end
    chk("stream.end_valid", 64'(out_valid), 64'd0);

    // Mid-stream reset clears a just-registered result without a clock edge.
    in_valid = 1'b1;
    data_in  = 8'h7F;
    @(posedge clk);
    #2;
    chk("pre_rst.cnt", 64'(cnt_out), 64'd7);
    rst_n = 1'b0;
    #1;
    chk_reset("async_rst");
    @(negedge clk);
    chk_reset("rst_held");
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk_reset("post_rst_idle");
    in_valid = 1'b1;
    data_in  = 8'h0D;
    @(negedge clk);
    chk("post_rst.valid",  64'(out_valid),  64'd1);
    chk("post_rst.cnt",    64'(cnt_out),    64'd3);
    chk("post_rst.parity", 64'(parity_out), 64'd1);

    // Width sweep: all-ones words, then a sparse word.
    d1 = 1'b1; d7 = 7'h7F; d16 = 16'hFFFF;
    @(negedge clk);
    chk("w1.cnt",   64'(c1),  64'd1);
    chk("w1.ones",  64'(o1),  64'd1);
    chk("w7.cnt",   64'(c7),  64'd7);
    chk("w7.ones",  64'(o7),  64'd1);
    chk("w7.par",   64'(p7),  64'd1);
    chk("w16.cnt",  64'(c16), 64'd16);
    chk("w16.ones", 64'(o16), 64'd1);
    chk("w16.par",  64'(p16), 64'd0);
    d1 = 1'b0; d7 = 7'h41; d16 = 16'h8001;
    @(negedge clk);
    chk("w1.zero",  64'(z1),  64'd1);
    chk("w1.cnt0",  64'(c1),  64'd0);
    chk("w7.cnt2",  64'(c7),  64'd2);
    chk("w16.cnt2", 64'(c16), 64'd2);
    chk("w16.ones0", 64'(o16), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
